fb_fade_engine: RTL and testbench
=================================

// Module: fb_fade_engine
// PURPOSE
//  Parametrised read-modify-write fade stage for fading frame buffers.
//  - Input: the pixel stream read from the fb (addr, age, color).
//  - Computes each pixel's next age and colour using a run-time selectable fade curve.
//  - Buffers the result for the fb writer's secondary (fade) port.
//  - Adds mode select, per-channel linear decay and saturating drop accounting.
// PARAMETERS
//  AXI_ADDR_WIDTH  20  fb address width
//  COLOR_BITS      4   bits per channel (3 channels: R,G,B, R in MSBs)
//  AGE_BITS        4   pixel age width; age 0 = not fading
//  HALF_AGE        2   STEP mode: colour halved when next_age == HALF_AGE
//  DECAY_STEP      1   LINEAR mode: amount subtracted per channel per age step
//  FIFO_ADDR_SIZE  3   output buffer depth = 2**FIFO_ADDR_SIZE
//  DROP_CNT_BITS   16  drop counter width
// PORTS
//  clk          in   1                    system clock
//  rst_n        in   1                    async active-low reset
//  fade_en      in   1                    0: no entries generated
//  fade_mode    in   2                    0 OFF, 1 STEP, 2 LINEAR, 3 SHIFT
//  in_valid     in   1                    pixel read from fb this cycle (no backpressure)
//  in_visible   in   1                    pixel lies in visible area
//  in_addr      in   AXI_ADDR_WIDTH       fb address of pixel
//  in_age       in   AGE_BITS             stored age
//  in_color     in   3*COLOR_BITS         stored colour
//  out_valid    out  1                    writeback entry available
//  out_ready    in   1                    writer accepts entry
//  out_addr     out  AXI_ADDR_WIDTH       writeback address
//  out_data     out  AGE_BITS+3*COLOR_BITS  {next_age, next_color}
//  drop_count   out  DROP_CNT_BITS        saturating count of lost writebacks
//  drop_clr     in   1                    synchronous clear of drop_count
// BEHAVIOUR
//  - Reset (async, rst_n=0): pipeline valids, FIFO and drop_count cleared.
//    out_valid=0; out_addr/out_data=0.
//  - Qualify: take = in_valid & in_visible & fade_en & (in_age!=0) & (fade_mode!=OFF).
//  - S1: register take, in_addr, in_age, in_color, fade_mode. Mode is sampled per pixel;
//    a mode change never alters entries already in flight.
//  - S2: register next values computed from S1. next_age = age-1.
//    - STEP: halve each channel iff next_age==HALF_AGE.
//    - LINEAR: ch = (ch>DECAY_STEP) ? ch-DECAY_STEP : 0.
//    - SHIFT: ch >>= 1 every step.
//    - All modes: next_age==0 forces colour 0 (pixel expires, cleared in fb).
//  - Push S2 into FIFO on the next edge. FIFO is first-word-fall-through:
//    in sampled at edge N -> out_valid high after edge N+2 (FIFO empty, out_ready=1).
//  - Pop on out_valid & out_ready. out_* stable while out_valid & !out_ready.
//  - FIFO full at push with no simultaneous pop: entry discarded; drop_count += 1,
//    saturating at all-ones.
//  - Full with simultaneous pop: push accepted, no drop.
//  - Empty: out_valid=0. Push into empty FIFO is visible next cycle, never same cycle.
//  - drop_clr: drop_count <= 0; a drop in the same cycle wins (count = 1).
//  - Throughput: one pixel/cycle sustained when out_ready=1.
//  - fade_en=0 or OFF: no new entries; queued entries still drain.
// STRUCTURE
//  - fb_fade_pkg holds:
//    - fade_mode_t enum (FADE_OFF/STEP/LINEAR/SHIFT).
//    - fade_pixel function: (mode, age, color) -> {age, color}.
//  - Buffer: existing sync_fifo (DATA_WIDTH = AXI_ADDR_WIDTH+AGE_BITS+3*COLOR_BITS,
//    ADDR_SIZE = FIFO_ADDR_SIZE). Its almost_full is unused.
//  - The top-level display block instantiates this block in place of its inline fade logic.
// TESTING
//  - STEP: in age=3 color=0xF84, addr=0x00100 -> 3 cycles later out_addr=0x00100,
//    out_data={2,0x742}.
//  - LINEAR, DECAY_STEP=1: age=5 color=0x301 -> {4,0x200}. Age=1 color=0xFFF -> {0,0x000}.
//  - Qualification: age=0, or in_visible=0, or fade_en=0, or mode OFF -> no out_valid
//    for 10 cycles.
//  - Backpressure: out_ready=0, stream 12 qualifying pixels, depth 8 -> 8 retained in order,
//    drop_count=4. Then out_ready=1 -> exactly 8 pops, addresses match first 8 inputs.
//  - Full with simultaneous pop while streaming, out_ready=1 -> drop_count stays 0.
//  - rst_n low mid-stream (4 entries queued) -> out_valid=0 immediately, drop_count=0.
//    After release, no stale entries are emitted.

Source files
------------

// File: rtl/fb_fade_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fb_fade_pkg
// Description : Shared fade-mode encoding and the per-pixel fade curve used by
//               the frame-buffer fade engine.
// Revision    : 1.0  initial release
// ============================================================================
package fb_fade_pkg;

  typedef enum logic [1:0] {
    FADE_OFF    = 2'd0,
    FADE_STEP   = 2'd1,
    FADE_LINEAR = 2'd2,
    FADE_SHIFT  = 2'd3
  } fade_mode_t;

  // Working width of the curve arithmetic; callers zero-extend into it and
  // truncate back, so any channel/age width up to this bound is supported.
  localparam int c_FADE_WORD_BITS = 16;

  typedef logic [c_FADE_WORD_BITS-1:0] fade_word_t;

  typedef struct packed {
    fade_word_t       age;
    fade_word_t [2:0] ch;
  } fade_pixel_t;

  // One fade step: age decrements, each channel follows the selected curve,
  // and a pixel whose age reaches zero expires to black.
  function automatic fade_pixel_t fade_pixel(
    input fade_mode_t       mode,
    input fade_word_t       age,
    input fade_word_t [2:0] color,
    input fade_word_t       half_age,
    input fade_word_t       decay_step
  );
    fade_pixel_t r;
    fade_word_t  c;
    r.age = age - fade_word_t'(1);
    for (int i = 0; i < 3; i++) begin
      c = color[i];
      case (mode)
        FADE_STEP:   if (r.age == half_age) c = c >> 1;
        FADE_LINEAR: c = (c > decay_step) ? (c - decay_step) : '0;
        FADE_SHIFT:  c = c >> 1;
        default:     c = color[i];
      endcase
      if (r.age == '0) c = '0;
      r.ch[i] = c;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock first-word-fall-through FIFO. A write into a full
//               FIFO is accepted when a read happens in the same cycle.
// Revision    : 1.0  initial release
// ============================================================================
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_SIZE  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full
);

  localparam logic [ADDR_SIZE:0] c_DEPTH = (ADDR_SIZE+1)'(1 << ADDR_SIZE);

  logic [DATA_WIDTH-1:0] r_mem [0:(1<<ADDR_SIZE)-1];
  logic [ADDR_SIZE-1:0]  r_wptr;
  logic [ADDR_SIZE-1:0]  r_rptr;
  logic [ADDR_SIZE:0]    r_count;
  logic                  w_do_rd;
  logic                  w_do_wr;

  assign full        = (r_count == c_DEPTH);
  assign empty       = (r_count == '0);
  assign almost_full = (r_count >= (c_DEPTH - 1'b1));
  assign w_do_rd     = rd_en & ~empty;
  assign w_do_wr     = wr_en & (~full | w_do_rd);
  assign rd_data     = r_mem[r_rptr];

  // Storage array; contents are only observable through a valid read pointer.
  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[r_wptr] <= wr_data;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_wr) r_wptr <= r_wptr + 1'b1;
      if (w_do_rd) r_rptr <= r_rptr + 1'b1;
      case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/fb_fade_engine.sv
`default_nettype none
// ============================================================================
// Module      : fb_fade_engine
// Description : Read-modify-write fade stage. Qualifies pixels read from the
//               frame buffer, computes next age/colour and queues writebacks
//               for the writer's fade port, counting entries lost to overflow.
// Revision    : 1.0  initial release
// ============================================================================
module fb_fade_engine
  import fb_fade_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 20,
  parameter int COLOR_BITS     = 4,
  parameter int AGE_BITS       = 4,
  parameter int HALF_AGE       = 2,
  parameter int DECAY_STEP     = 1,
  parameter int FIFO_ADDR_SIZE = 3,
  parameter int DROP_CNT_BITS  = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             fade_en,
  input  logic [1:0]                       fade_mode,
  input  logic                             in_valid,
  input  logic                             in_visible,
  input  logic [AXI_ADDR_WIDTH-1:0]        in_addr,
  input  logic [AGE_BITS-1:0]              in_age,
  input  logic [3*COLOR_BITS-1:0]          in_color,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [AXI_ADDR_WIDTH-1:0]        out_addr,
  output logic [AGE_BITS+3*COLOR_BITS-1:0] out_data,
  output logic [DROP_CNT_BITS-1:0]         drop_count,
  input  logic                             drop_clr
);

  localparam int c_DATA_W = AGE_BITS + 3*COLOR_BITS;
  localparam int c_FIFO_W = AXI_ADDR_WIDTH + c_DATA_W;

  logic                      w_take;
  logic                      r_s1_valid;
  logic [AXI_ADDR_WIDTH-1:0] r_s1_addr;
  logic [AGE_BITS-1:0]       r_s1_age;
  logic [3*COLOR_BITS-1:0]   r_s1_color;
  fade_mode_t                r_s1_mode;

  fade_word_t [2:0]          w_ch;
  fade_pixel_t               w_px;
  logic [c_DATA_W-1:0]       w_next;

  logic                      r_s2_valid;
  logic [AXI_ADDR_WIDTH-1:0] r_s2_addr;
  logic [c_DATA_W-1:0]       r_s2_data;

  logic [c_FIFO_W-1:0]       w_rd_data;
  logic                      w_full;
  logic                      w_empty;
  logic                      w_almost_full;
  logic                      w_pop;
  logic                      w_drop;

  assign w_take = in_valid & in_visible & fade_en & (in_age != '0) &
                  (fade_mode_t'(fade_mode) != FADE_OFF);

  // S1: capture the qualified pixel together with the mode it was read under.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_addr  <= '0;
      r_s1_age   <= '0;
      r_s1_color <= '0;
      r_s1_mode  <= FADE_OFF;
    end else begin
      r_s1_valid <= w_take;
      r_s1_addr  <= in_addr;
      r_s1_age   <= in_age;
      r_s1_color <= in_color;
      r_s1_mode  <= fade_mode_t'(fade_mode);
    end
  end

  // Channel 0 is blue (LSBs), channel 2 is red (MSBs).
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_ch
      assign w_ch[gi] = fade_word_t'(r_s1_color[gi*COLOR_BITS +: COLOR_BITS]);
      assign w_next[gi*COLOR_BITS +: COLOR_BITS] = w_px.ch[gi][COLOR_BITS-1:0];
    end
  endgenerate

  assign w_px = fade_pixel(r_s1_mode, fade_word_t'(r_s1_age), w_ch,
                           fade_word_t'(HALF_AGE), fade_word_t'(DECAY_STEP));
  assign w_next[c_DATA_W-1 -: AGE_BITS] = w_px.age[AGE_BITS-1:0];

  // S2: register the faded result; it is pushed into the buffer next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_addr  <= '0;
      r_s2_data  <= '0;
    end else begin
      r_s2_valid <= r_s1_valid;
      r_s2_addr  <= r_s1_addr;
      r_s2_data  <= w_next;
    end
  end

  sync_fifo #(
    .DATA_WIDTH (c_FIFO_W),
    .ADDR_SIZE  (FIFO_ADDR_SIZE)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (r_s2_valid),
    .wr_data     ({r_s2_addr, r_s2_data}),
    .rd_en       (w_pop),
    .rd_data     (w_rd_data),
    .full        (w_full),
    .empty       (w_empty),
    .almost_full (w_almost_full)
  );

  assign out_valid = ~w_empty;
  assign w_pop     = out_valid & out_ready;
  assign out_addr  = out_valid ? w_rd_data[c_FIFO_W-1 -: AXI_ADDR_WIDTH] : '0;
  assign out_data  = out_valid ? w_rd_data[c_DATA_W-1:0] : '0;

  // A push is lost only when the buffer is full and nothing leaves this cycle.
  assign w_drop = r_s2_valid & w_full & ~w_pop;

  // Saturating drop counter; a drop coinciding with a clear still counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_count <= '0;
    end else if (drop_clr) begin
      drop_count <= w_drop ? DROP_CNT_BITS'(1) : '0;
    end else if (w_drop && (drop_count != '1)) begin
      drop_count <= drop_count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fb_fade_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_fb_fade_engine
// Description : Directed self-checking bench for fb_fade_engine.
// Revision    : 1.0  initial release
// ============================================================================
module tb_fb_fade_engine;

  localparam int AW = 20;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fade_en;
  logic [1:0]    fade_mode;
  logic          in_valid;
  logic          in_visible;
  logic [AW-1:0] in_addr;
  logic [3:0]    in_age;
  logic [11:0]   in_color;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;
  logic [15:0]   drop_count;
  logic          drop_clr;

  int n_cmp = 0;
  int n_bad = 0;

  fb_fade_engine u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fade_en    (fade_en),
    .fade_mode  (fade_mode),
    .in_valid   (in_valid),
    .in_visible (in_visible),
    .in_addr    (in_addr),
    .in_age     (in_age),
    .in_color   (in_color),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_addr   (out_addr),
    .out_data   (out_data),
    .drop_count (drop_count),
    .drop_clr   (drop_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic px(input logic [AW-1:0] a, input logic [3:0] age, input logic [11:0] col);
    in_valid = 1'b1;
    in_addr  = a;
    in_age   = age;
    in_color = col;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  // Single pixel: check latency (not yet valid after 2 edges, valid after 3).
  task automatic one(input string tag, input logic [1:0] mode, input logic [AW-1:0] a,
                     input logic [3:0] age, input logic [11:0] col, input logic [DW-1:0] exp);
    @(negedge clk);
    fade_mode = mode;
    px(a, age, col);
    @(negedge clk); idle();
    @(negedge clk);
    chk({tag, "_early"}, out_valid, 1'b0);
    @(negedge clk);
    chk({tag, "_valid"}, out_valid, 1'b1);
    chk({tag, "_addr"}, out_addr, a);
    chk({tag, "_data"}, out_data, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int pops;
    logic seen;
    rst_n = 1'b0; fade_en = 1'b1; fade_mode = 2'd1; in_valid = 1'b0;
    in_visible = 1'b1; in_addr = '0; in_age = '0; in_color = '0;
    out_ready = 1'b1; drop_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_addr", out_addr, '0);
    chk("rst_data", out_data, '0);
    chk("rst_drop", drop_count, '0);
    rst_n = 1'b1;

    // Fade curves.
    one("step_half", 2'd1, 20'h00100, 4'd3, 12'hF84, 16'h2742);
    @(negedge clk);
    chk("step_popped", out_valid, 1'b0);
    one("step_nohalf", 2'd1, 20'h00104, 4'd5, 12'hF84, 16'h4F84);
    one("lin_a", 2'd2, 20'h00200, 4'd5, 12'h301, 16'h4200);
    one("lin_expire", 2'd2, 20'h00201, 4'd1, 12'hFFF, 16'h0000);
    one("shift", 2'd3, 20'h00300, 4'd4, 12'h8F2, 16'h3471);
    @(negedge clk);

    // Qualification: age 0, invisible, disabled, mode OFF.
    for (int q = 0; q < 4; q++) begin
      @(negedge clk);
      fade_en    = (q != 2);
      fade_mode  = (q == 3) ? 2'd0 : 2'd1;
      in_visible = (q != 1);
      px(20'h00400, (q == 0) ? 4'd0 : 4'd3, 12'h555);
      @(negedge clk); idle();
      seen = 1'b0;
      repeat (10) begin
        @(negedge clk);
        if (out_valid) seen = 1'b1;
      end
      chk($sformatf("qual%0d", q), seen, 1'b0);
    end
    fade_en = 1'b1; fade_mode = 2'd1; in_visible = 1'b1;

    // Backpressure: 12 pixels into depth 8 -> 4 dropped, first 8 kept in order.
    out_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); px(AW'(20'h10 + i), 4'd7, 12'h111);
    end
    @(negedge clk); idle();
    repeat (3) @(negedge clk);
    chk("bp_drop", drop_count, 16'd4);
    chk("bp_hold_addr", out_addr, 20'h10);
    chk("bp_hold_data", out_data, 16'h6111);
    out_ready = 1'b1;
    pops = 0;
    for (int k = 0; k < 20; k++) begin
      if (out_valid) begin
        chk("bp_order", out_addr, AW'(20'h10 + pops));
        pops++;
      end
      @(negedge clk);
    end
    chk("bp_pops", pops, 8);

    // Clear, then a drop landing on the same edge as a clear counts as one.
    drop_clr = 1'b1; @(negedge clk); drop_clr = 1'b0;
    chk("clr", drop_count, 16'd0);
    out_ready = 1'b0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk); px(AW'(20'h20 + i), 4'd7, 12'h111);
    end
    @(negedge clk); idle();
    @(negedge clk); drop_clr = 1'b1;
    @(negedge clk); drop_clr = 1'b0;
    chk("clr_drop_wins", drop_count, 16'd1);
    out_ready = 1'b1;
    repeat (12) @(negedge clk);
    drop_clr = 1'b1; @(negedge clk); drop_clr = 1'b0;

    // Full with simultaneous pop while streaming: nothing may be lost.
    out_ready = 1'b0;
    pops = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      px(AW'(20'h40 + i), 4'd7, 12'h111);
      if (i == 10) out_ready = 1'b1;
      if (out_ready && out_valid) begin
        chk("fp_order", out_addr, AW'(20'h40 + pops));
        pops++;
      end
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      idle();
      if (out_valid) begin
        chk("fp_order", out_addr, AW'(20'h40 + pops));
        pops++;
      end
    end
    chk("fp_pops", pops, 14);
    chk("fp_drop", drop_count, 16'd0);

    // Asynchronous reset with a full buffer and pending drops.
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); px(AW'(20'h80 + i), 4'd7, 12'h111);
    end
    @(negedge clk); idle();
    repeat (3) @(negedge clk);
    chk("pre_rst_valid", out_valid, 1'b1);
    chk("pre_rst_drop", drop_count, 16'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_drop", drop_count, 16'd0);
    chk("mid_rst_addr", out_addr, '0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("post_rst_stale", seen, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
